// File: rtl/display_pkg.sv
// Shared constants for the BCD display scanner: segment patterns, digit
// positions and the adjust-field encoding.
package display_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  localparam logic [2:0] DIG_HT = 3'd0;
  localparam logic [2:0] DIG_HU = 3'd1;
  localparam logic [2:0] DIG_MT = 3'd2;
  localparam logic [2:0] DIG_MU = 3'd3;
  localparam logic [2:0] DIG_ST = 3'd4;
  localparam logic [2:0] DIG_SU = 3'd5;

  typedef enum logic [1:0] {
    FLD_HOURS   = 2'd0,
    FLD_MINUTES = 2'd1,
    FLD_SECONDS = 2'd2,
    FLD_NONE    = 2'd3
  } adj_field_t;

  // True when digit position d belongs to the field being adjusted.
  function automatic logic field_covers(input adj_field_t fld, input logic [2:0] d);
    logic hit;
    hit = 1'b0;
    case (fld)
      FLD_HOURS:   hit = (d == DIG_HT) || (d == DIG_HU);
      FLD_MINUTES: hit = (d == DIG_MT) || (d == DIG_MU);
      FLD_SECONDS: hit = (d == DIG_ST) || (d == DIG_SU);
      default:     hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 show a dash.
module bcd_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_DIGIT[0];
      4'd1: seg = SEG_DIGIT[1];
      4'd2: seg = SEG_DIGIT[2];
      4'd3: seg = SEG_DIGIT[3];
      4'd4: seg = SEG_DIGIT[4];
      4'd5: seg = SEG_DIGIT[5];
      4'd6: seg = SEG_DIGIT[6];
      4'd7: seg = SEG_DIGIT[7];
      4'd8: seg = SEG_DIGIT[8];
      4'd9: seg = SEG_DIGIT[9];
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Six-digit multiplexed 7-segment driver with per-frame snapshot of the time
// digits, anti-ghosting blank window and field blinking during time adjust.
module bcd_display_scanner
  import display_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 1,
  parameter int BLINK_DIV    = 12500000,
  parameter bit LZ_BLANK     = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] hour_tens,
  input  logic [3:0] hour_units,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_units,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_units,
  input  logic       adjust,
  input  logic [1:0] adjust_field,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SW-1:0] scan_cnt;
  logic [2:0]    digit_idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_vis;
  logic [3:0]    snapshot [6];

  logic [3:0] cur_digit;
  logic [6:0] seg_next;
  logic       suppressed;
  logic       an_off;
  logic [5:0] an_next;
  logic       dp_next;
  logic       frame_end;

  assign frame_end = (digit_idx == DIG_SU) && (scan_cnt == SCAN_LAST);

  // Slot timing, digit rotation and the frame-end snapshot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt  <= '0;
      digit_idx <= DIG_HT;
      for (int i = 0; i < 6; i++) snapshot[i] <= 4'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == DIG_SU) ? DIG_HT : digit_idx + 3'd1;
      if (frame_end) begin
        snapshot[0] <= hour_tens;
        snapshot[1] <= hour_units;
        snapshot[2] <= min_tens;
        snapshot[3] <= min_units;
        snapshot[4] <= sec_tens;
        snapshot[5] <= sec_units;
      end
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // Blink phase restarts visible whenever adjust is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      blink_vis <= 1'b1;
    end else if (!adjust) begin
      blink_cnt <= '0;
      blink_vis <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_vis <= ~blink_vis;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  always_comb begin
    cur_digit = snapshot[0];
    case (digit_idx)
      DIG_HT:  cur_digit = snapshot[0];
      DIG_HU:  cur_digit = snapshot[1];
      DIG_MT:  cur_digit = snapshot[2];
      DIG_MU:  cur_digit = snapshot[3];
      DIG_ST:  cur_digit = snapshot[4];
      DIG_SU:  cur_digit = snapshot[5];
      default: cur_digit = snapshot[0];
    endcase
  end

  bcd_to_7seg u_dec (
    .bcd (cur_digit),
    .seg (seg_next)
  );

  // Gating with adjust makes a dropped adjust visible on the very next cycle.
  always_comb begin
    suppressed = adjust && !blink_vis &&
                 field_covers(adj_field_t'(adjust_field), digit_idx);
    an_off     = (scan_cnt < BLANK_END) || suppressed ||
                 (LZ_BLANK && (digit_idx == DIG_HT) && (snapshot[0] == 4'd0));
    an_next    = an_off ? 6'h3F : ~(6'b000001 << digit_idx);
    dp_next    = !((digit_idx == DIG_HU) || (digit_idx == DIG_MU));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= 6'h3F;
    end else begin
      seg <= seg_next;
      dp  <= dp_next;
      an  <= an_next;
    end
  end

endmodule
